ariane_wakeup_ctrl: RTL and testbench

Parametrised core wake-up and interrupt-synchronisation controller that sits between the OpenPiton tile and the `ariane` core instance. It gates the core reset until a configurable wake condition is met: a fixed SRAM-init delay, the first L1.5 interrupt return, or whichever comes first. It then releases reset through an async-assert/sync-deassert chain. It also synchronises a configurable number of asynchronous interrupt lines, and supports a software sleep request that puts the core back into reset and re-arms the wake logic.

---
 rtl/ariane_wakeup_ctrl_if.sv | 44 ++++
 rtl/ariane_wakeup_ctrl.sv | 100 ++++++++++
 tb/tb_ariane_wakeup_ctrl.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/ariane_wakeup_ctrl_if.sv
// ariane_wakeup_ctrl_if
//   Bundles the tile-side wake/sleep handshake, the raw asynchronous
//   interrupt lines and the controller's outputs towards the core.
//   slave  : the wake-up controller (consumes requests, drives core side)
//   master : the tile / environment (drives requests, observes outputs)
//   Signals:
//     wake_int_i   L15 interrupt-packet pulse (clk_i domain)
//     sleep_req_i  software sleep request (clk_i domain)
//     irq_i        NumIrq async level interrupts
//     ipi_i, time_irq_i, debug_req_i  async single-bit requests
//     core_rst_no  active-low core reset
//     awake_o      controller is in RUN
//     wake_cnt_o   wake counter, debug visibility
//     irq_o, ipi_o, time_irq_o, debug_req_o  synchronised interrupts
interface ariane_wakeup_ctrl_if #(
    parameter int unsigned WakeCntWidth = 16,
    parameter int unsigned NumIrq       = 2
);
    logic                    wake_int_i;
    logic                    sleep_req_i;
    logic [NumIrq-1:0]       irq_i;
    logic                    ipi_i;
    logic                    time_irq_i;
    logic                    debug_req_i;
    logic                    core_rst_no;
    logic                    awake_o;
    logic [WakeCntWidth-1:0] wake_cnt_o;
    logic [NumIrq-1:0]       irq_o;
    logic                    ipi_o;
    logic                    time_irq_o;
    logic                    debug_req_o;

    modport slave (
        input  wake_int_i, sleep_req_i, irq_i, ipi_i, time_irq_i, debug_req_i,
        output core_rst_no, awake_o, wake_cnt_o, irq_o, ipi_o, time_irq_o,
               debug_req_o
    );

    modport master (
        output wake_int_i, sleep_req_i, irq_i, ipi_i, time_irq_i, debug_req_i,
        input  core_rst_no, awake_o, wake_cnt_o, irq_o, ipi_o, time_irq_o,
               debug_req_o
    );
endinterface

// File: rtl/ariane_wakeup_ctrl.sv
// ariane_wakeup_ctrl
//   Holds the ariane core in reset until a wake condition (SRAM-init delay
//   counter, first L15 interrupt return, or either) is reached, then releases
//   reset through an async-assert / sync-deassert chain. A sleep request in
//   RUN puts the core back into reset and re-arms the wake logic. Also
//   synchronises the asynchronous interrupt lines into clk_i.
//   Ports:
//     clk_i  sole clock
//     rst_i  asynchronous active-high reset
//     bus    ariane_wakeup_ctrl_if.slave (see interface header)
//   Parameters:
//     WakeCntWidth  counter width, counter delay is 2^(WakeCntWidth-1) (>=2)
//     WakeMode      0 counter, 1 interrupt, 2 first of either
//     NumIrq        number of external level interrupts
//     SyncStages    depth of every synchroniser and the reset chain (>=2)
module ariane_wakeup_ctrl #(
    parameter int unsigned WakeCntWidth = 16,
    parameter int unsigned WakeMode     = 0,
    parameter int unsigned NumIrq       = 2,
    parameter int unsigned SyncStages   = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    ariane_wakeup_ctrl_if.slave bus
);

    localparam int unsigned NumSync = NumIrq + 3;

    typedef enum logic {
        WAIT = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e                              state_q;
    logic [WakeCntWidth-1:0]             cnt_q;
    logic [WakeCntWidth-1:0]             cnt_inc;
    logic [SyncStages-1:0]               rst_chain_q;
    logic [SyncStages-1:0][NumSync-1:0]  sync_q;
    logic [NumSync-1:0]                  sync_in;
    logic                                cnt_en;
    logic                                int_en;
    logic                                wake_now;
    logic                                chain_in;

    assign cnt_en = (WakeMode != 1);
    assign int_en = (WakeMode != 0);

    always_comb begin
        cnt_inc  = cnt_q + WakeCntWidth'(1);
        wake_now = (cnt_en && cnt_inc[WakeCntWidth-1]) || (int_en && bus.wake_int_i);
        // Stage 0 samples the next awake value rather than awake_o itself, so
        // the core reset deasserts SyncStages-1 edges after awake_o rises.
        chain_in = (state_q == RUN) ? ~bus.sleep_req_i : wake_now;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= WAIT;
            cnt_q       <= '0;
            rst_chain_q <= '0;
        end else begin
            rst_chain_q <= {rst_chain_q[SyncStages-2:0], chain_in};
            case (state_q)
                WAIT: begin
                    // Counter keeps its incremented value even when the
                    // interrupt wins the race on the same edge.
                    if (cnt_en) cnt_q <= cnt_inc;
                    if (wake_now) state_q <= RUN;
                end
                RUN: begin
                    if (bus.sleep_req_i) begin
                        state_q     <= WAIT;
                        cnt_q       <= '0;
                        rst_chain_q <= '0;
                    end
                end
                default: state_q <= WAIT;
            endcase
        end
    end

    assign sync_in = {bus.debug_req_i, bus.time_irq_i, bus.ipi_i, bus.irq_i};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SyncStages-2:0], sync_in};
        end
    end

    assign bus.awake_o     = (state_q == RUN);
    assign bus.core_rst_no = rst_chain_q[SyncStages-1];
    assign bus.wake_cnt_o  = cnt_q;
    assign bus.irq_o       = sync_q[SyncStages-1][NumIrq-1:0];
    assign bus.ipi_o       = sync_q[SyncStages-1][NumIrq];
    assign bus.time_irq_o  = sync_q[SyncStages-1][NumIrq+1];
    assign bus.debug_req_o = sync_q[SyncStages-1][NumIrq+2];

endmodule

// File: tb/tb_ariane_wakeup_ctrl.sv
// tb_ariane_wakeup_ctrl
//   Three controllers run side by side from a common clock and reset:
//     u0: counter mode,   W=4, SyncStages=2
//     u1: interrupt mode, W=4, SyncStages=2
//     u2: either mode,    W=4, SyncStages=3, NumIrq=3 (also used for sync)
//   Edge n is the n-th rising clk edge after rst falls; outputs are sampled
//   1 ns after that edge.
module tb_ariane_wakeup_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   nvec  = 0;
    int   nfail = 0;

    always #5 clk = ~clk;

    ariane_wakeup_ctrl_if #(.WakeCntWidth(4), .NumIrq(3)) if0 ();
    ariane_wakeup_ctrl_if #(.WakeCntWidth(4), .NumIrq(3)) if1 ();
    ariane_wakeup_ctrl_if #(.WakeCntWidth(4), .NumIrq(3)) if2 ();

    ariane_wakeup_ctrl #(.WakeCntWidth(4), .WakeMode(0), .NumIrq(3), .SyncStages(2))
        u0 (.clk_i(clk), .rst_i(rst), .bus(if0));
    ariane_wakeup_ctrl #(.WakeCntWidth(4), .WakeMode(1), .NumIrq(3), .SyncStages(2))
        u1 (.clk_i(clk), .rst_i(rst), .bus(if1));
    ariane_wakeup_ctrl #(.WakeCntWidth(4), .WakeMode(2), .NumIrq(3), .SyncStages(3))
        u2 (.clk_i(clk), .rst_i(rst), .bus(if2));

    // bit 0 = u0, bit 1 = u1, bit 2 = u2
    typedef struct {
        int         e;
        logic [2:0] awake;
        logic [2:0] rstn;
        int         cnt0;
        int         cnt1;
        int         cnt2;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_inputs();
        if0.wake_int_i = 0; if0.sleep_req_i = 0; if0.irq_i = '0;
        if0.ipi_i = 0; if0.time_irq_i = 0; if0.debug_req_i = 0;
        if1.wake_int_i = 0; if1.sleep_req_i = 0; if1.irq_i = '0;
        if1.ipi_i = 0; if1.time_irq_i = 0; if1.debug_req_i = 0;
        if2.wake_int_i = 0; if2.sleep_req_i = 0; if2.irq_i = '0;
        if2.ipi_i = 0; if2.time_irq_i = 0; if2.debug_req_i = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        clr_inputs();
        repeat (2) tick();
        rst = 0;
    endtask

    function automatic logic [2:0] awake_v();
        return {if2.awake_o, if1.awake_o, if0.awake_o};
    endfunction

    function automatic logic [2:0] rstn_v();
        return {if2.core_rst_no, if1.core_rst_no, if0.core_rst_no};
    endfunction

    initial begin
        //            e  awake   rstn    c0 c1 c2
        tbl[0]  = '{0,  3'b000, 3'b000, 0, 0, 0};
        tbl[1]  = '{1,  3'b000, 3'b000, 1, 0, 1};
        tbl[2]  = '{2,  3'b000, 3'b000, 2, 0, 2};
        tbl[3]  = '{3,  3'b100, 3'b000, 3, 0, 3};
        tbl[4]  = '{4,  3'b100, 3'b000, 4, 0, 3};
        tbl[5]  = '{5,  3'b110, 3'b100, 5, 0, 3};
        tbl[6]  = '{6,  3'b110, 3'b110, 6, 0, 3};
        tbl[7]  = '{7,  3'b110, 3'b110, 7, 0, 3};
        tbl[8]  = '{8,  3'b111, 3'b110, 8, 0, 3};
        tbl[9]  = '{9,  3'b111, 3'b111, 8, 0, 3};
        tbl[10] = '{10, 3'b111, 3'b111, 8, 0, 3};

        // Reset state while rst is held.
        clr_inputs();
        #1 rst = 1;
        #2;
        chk("reset_awake", int'(awake_v()), 0);
        chk("reset_rstn", int'(rstn_v()), 0);
        chk("reset_cnt0", int'(if0.wake_cnt_o), 0);
        chk("reset_irq2", int'(if2.irq_o), 0);

        // Main run: u1 pulse at edge 5, u2 pulse at edge 3, u0 counts.
        do_reset();
        foreach (tbl[i]) begin
            if (tbl[i].e > 0) begin
                if1.wake_int_i = (tbl[i].e == 5);
                if2.wake_int_i = (tbl[i].e == 3);
                tick();
            end
            chk($sformatf("tbl%0d_awake", tbl[i].e), int'(awake_v()), int'(tbl[i].awake));
            chk($sformatf("tbl%0d_rstn", tbl[i].e), int'(rstn_v()), int'(tbl[i].rstn));
            chk($sformatf("tbl%0d_cnt0", tbl[i].e), int'(if0.wake_cnt_o), tbl[i].cnt0);
            chk($sformatf("tbl%0d_cnt1", tbl[i].e), int'(if1.wake_cnt_o), tbl[i].cnt1);
            chk($sformatf("tbl%0d_cnt2", tbl[i].e), int'(if2.wake_cnt_o), tbl[i].cnt2);
        end
        if1.wake_int_i = 0;
        if2.wake_int_i = 0;

        // Sleep together with wake_int in RUN: sleep wins.
        if0.sleep_req_i = 1; if0.wake_int_i = 1;
        if1.sleep_req_i = 1; if1.wake_int_i = 1;
        tick();
        chk("sleep_awake0", int'(if0.awake_o), 0);
        chk("sleep_rstn0", int'(if0.core_rst_no), 0);
        chk("sleep_cnt0", int'(if0.wake_cnt_o), 0);
        chk("sleep_awake1", int'(if1.awake_o), 0);
        chk("sleep_rstn1", int'(if1.core_rst_no), 0);
        if0.sleep_req_i = 0; if0.wake_int_i = 0;
        if1.sleep_req_i = 0; if1.wake_int_i = 1;
        tick();  // re-wake edge 1
        chk("rewake1_awake", int'(if1.awake_o), 1);
        chk("rewake1_rstn", int'(if1.core_rst_no), 0);
        chk("rewake0_cnt_e1", int'(if0.wake_cnt_o), 1);
        if1.wake_int_i = 0;
        tick();  // edge 2
        chk("rewake1_rstn_e2", int'(if1.core_rst_no), 1);
        if0.sleep_req_i = 1;  // ignored while waiting
        tick();  // edge 3
        chk("sleep_in_wait_cnt0", int'(if0.wake_cnt_o), 3);
        if0.sleep_req_i = 0;
        for (int e = 4; e <= 9; e++) begin
            tick();
            if (e == 7) begin
                chk("rewake0_awake_e7", int'(if0.awake_o), 0);
                chk("rewake0_cnt_e7", int'(if0.wake_cnt_o), 7);
            end
            if (e == 8) begin
                chk("rewake0_awake_e8", int'(if0.awake_o), 1);
                chk("rewake0_rstn_e8", int'(if0.core_rst_no), 0);
                chk("rewake0_cnt_e8", int'(if0.wake_cnt_o), 8);
            end
            if (e == 9) chk("rewake0_rstn_e9", int'(if0.core_rst_no), 1);
        end

        // Either mode, no pulse: counter wake at edge 8.
        do_reset();
        for (int e = 1; e <= 8; e++) begin
            tick();
            if (e == 7) chk("either_nopulse_awake_e7", int'(if2.awake_o), 0);
        end
        chk("either_nopulse_awake_e8", int'(if2.awake_o), 1);
        chk("either_nopulse_cnt_e8", int'(if2.wake_cnt_o), 8);

        // Either mode, pulse coinciding with counter wake at edge 8.
        do_reset();
        for (int e = 1; e <= 10; e++) begin
            if2.wake_int_i = (e == 8);
            tick();
            if (e == 7) chk("either_race_awake_e7", int'(if2.awake_o), 0);
            if (e == 8) begin
                chk("either_race_awake_e8", int'(if2.awake_o), 1);
                chk("either_race_cnt_e8", int'(if2.wake_cnt_o), 8);
            end
            if (e == 9) begin
                chk("either_race_awake_e9", int'(if2.awake_o), 1);
                chk("either_race_rstn_e9", int'(if2.core_rst_no), 0);
            end
            if (e == 10) begin
                chk("either_race_rstn_e10", int'(if2.core_rst_no), 1);
                chk("either_race_cnt_e10", int'(if2.wake_cnt_o), 8);
            end
        end
        if2.wake_int_i = 0;

        // Async reset mid-count (u0 at 5) and mid-RUN (u1).
        do_reset();
        if1.wake_int_i = 1;
        tick();
        if1.wake_int_i = 0;
        repeat (4) tick();
        chk("pre_arst_cnt0", int'(if0.wake_cnt_o), 5);
        chk("pre_arst_rstn1", int'(if1.core_rst_no), 1);
        rst = 1;
        #1;
        chk("arst_cnt0", int'(if0.wake_cnt_o), 0);
        chk("arst_awake", int'(awake_v()), 0);
        chk("arst_rstn", int'(rstn_v()), 0);
        #2 rst = 0;
        tick();
        chk("arst_restart_cnt0", int'(if0.wake_cnt_o), 1);
        chk("arst_restart_awake1", int'(if1.awake_o), 0);

        // Interrupt synchronisers on u2 (SyncStages=3).
        rst = 1;
        clr_inputs();
        if2.irq_i = 3'b111;
        if2.debug_req_i = 1;
        repeat (3) tick();
        chk("sync_in_reset_irq", int'(if2.irq_o), 0);
        chk("sync_in_reset_dbg", int'(if2.debug_req_o), 0);
        rst = 0;
        if2.irq_i = '0;
        if2.debug_req_i = 0;
        repeat (3) tick();
        if2.irq_i = 3'b101;
        tick();
        chk("sync_irq_e1", int'(if2.irq_o), 0);
        tick();
        chk("sync_irq_e2", int'(if2.irq_o), 0);
        tick();
        chk("sync_irq_e3", int'(if2.irq_o), 5);
        if2.debug_req_i = 1;
        tick();
        chk("sync_dbg_e1", int'(if2.debug_req_o), 0);
        tick();
        chk("sync_dbg_e2", int'(if2.debug_req_o), 0);
        tick();
        chk("sync_dbg_e3", int'(if2.debug_req_o), 1);
        chk("sync_irq_hold", int'(if2.irq_o), 5);
        chk("sync_ipi_quiet", int'({if2.ipi_o, if2.time_irq_o}), 0);
        rst = 1;
        #1;
        chk("sync_arst_irq", int'(if2.irq_o), 0);
        chk("sync_arst_dbg", int'(if2.debug_req_o), 0);
        rst = 0;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
